// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter
// Shares one external memory bus between the instruction-fetch port (PC)
// and the data-access (MEM) port of the MIPS pipeline. One transaction is
// outstanding at a time. Data wins a collision until it has been granted
// MAX_DATA_STREAK times in a row against a waiting fetch; the fetch is then
// forced through. A bus cycle that never completes is aborted after TIMEOUT
// cycles and reported back through err_o with zero read data.
module ibus_dbus_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst,

  // instruction fetch port
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_ack_o,

  // data access port
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ack_o,

  // shared completion status
  output logic        err_o,

  // external memory bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,

  // pipeline hold request
  output logic        stall_o
);

  // Counter widths; a zero-valued parameter still needs a one-bit register.
  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  // Value the timeout counter holds during the last bus cycle allowed to
  // wait; if no ack shows up in that cycle the transfer is aborted.
  localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo_cnt;

  logic          fetch_forced;
  logic          grant_d;
  logic          grant_i;
  logic          tmo_hit;
  logic          bus_done;

  // Streak update on a data grant: it only grows while a fetch is actually
  // waiting behind the data access, and it never exceeds the limit.
  function automatic logic [SW-1:0] streak_next(input logic [SW-1:0] cur,
                                                input logic          fetch_waiting);
    if (!fetch_waiting) begin
      return '0;
    end
    if (cur == STREAK_MAX) begin
      return cur;
    end
    return cur + 1'b1;
  endfunction

  // Read data returned to the requester: bus data on a real completion,
  // zero when the transfer was aborted by the timeout.
  function automatic logic [31:0] resp_data(input logic        acked,
                                            input logic [31:0] rdata);
    return acked ? rdata : 32'h0;
  endfunction

  // Grant decision, evaluated only in IDLE: data first unless the streak
  // limit has been reached with a fetch waiting.
  always_comb begin
    fetch_forced = inst_req_i && (streak == STREAK_MAX);
    grant_d      = data_req_i && !fetch_forced;
    grant_i      = inst_req_i && !grant_d;
    tmo_hit      = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    bus_done     = bus_ack_i || tmo_hit;
  end

  // Pipeline hold: a requester is held until the cycle its ack is returned.
  assign stall_o = (inst_req_i && !inst_ack_o) || (data_req_i && !data_ack_o);

  // Arbiter FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      streak       <= '0;
      tmo_cnt      <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_sel_o    <= 4'h0;
      bus_addr_o   <= 32'h0;
      bus_wdata_o  <= 32'h0;
      inst_ack_o   <= 1'b0;
      inst_rdata_o <= 32'h0;
      data_ack_o   <= 1'b0;
      data_rdata_o <= 32'h0;
      err_o        <= 1'b0;
    end else begin
      // acks and err are single-cycle pulses that live only in RESP
      inst_ack_o <= 1'b0;
      data_ack_o <= 1'b0;
      err_o      <= 1'b0;

      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_d) begin
            state       <= BUSY_D;
            bus_req_o   <= 1'b1;
            bus_we_o    <= data_we_i;
            bus_sel_o   <= data_sel_i;
            bus_addr_o  <= data_addr_i;
            bus_wdata_o <= data_wdata_i;
            streak      <= streak_next(streak, inst_req_i);
          end else if (grant_i) begin
            // fetches are always full-word reads
            state       <= BUSY_I;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'hF;
            bus_addr_o  <= inst_addr_i;
            bus_wdata_o <= 32'h0;
            streak      <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          // a real ack in the last allowed cycle wins over the abort
          if (bus_done) begin
            state     <= RESP;
            bus_req_o <= 1'b0;
            tmo_cnt   <= '0;
            err_o     <= !bus_ack_i;
            if (state == BUSY_D) begin
              data_ack_o   <= 1'b1;
              data_rdata_o <= resp_data(bus_ack_i, bus_rdata_i);
            end else begin
              inst_ack_o   <= 1'b1;
              inst_rdata_o <= resp_data(bus_ack_i, bus_rdata_i);
            end
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RESP: begin
          // requests still high here belong to the transfer just answered
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Testbench for ibus_dbus_arbiter: directed scenarios plus a randomized
// phase, all checked against a timestamp-based transaction model.
module tb_ibus_dbus_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata_o;
  logic        inst_ack_o;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata_o;
  logic        data_ack_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_o;

  ibus_dbus_arbiter #(
    .MAX_DATA_STREAK(MAXS),
    .TIMEOUT        (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req_i  (inst_req),
    .inst_addr_i (inst_addr),
    .inst_rdata_o(inst_rdata_o),
    .inst_ack_o  (inst_ack_o),
    .data_req_i  (data_req),
    .data_we_i   (data_we),
    .data_sel_i  (data_sel),
    .data_addr_i (data_addr),
    .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata_o),
    .data_ack_o  (data_ack_o),
    .err_o       (err_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata),
    .bus_ack_i   (bus_ack),
    .stall_o     (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: one transaction described by its timestamps
  int          m_owner;      // 0 none, 1 fetch, 2 data
  int          m_start, m_end, m_resp, m_ackc, m_free, m_late;
  int          m_iack_last, m_dack_last, m_streak;
  logic [31:0] m_addr, m_wdata, m_rdata, m_irdata, m_drdata;
  logic        m_we, m_tmo;
  logic [3:0]  m_sel;

  // stimulus knobs (percent probabilities) and bus slave behaviour
  int i_raise, i_renew, i_drop, d_raise, d_renew, d_drop;
  int i_seq, lat_mode, lat_fixed, late_idle, rd_fixed_en;
  logic [31:0] rd_fixed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [31:0] next_iaddr();
    if (i_seq != 0) return inst_addr + 32'd4;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic new_dpayload();
    data_we    = 1'($urandom_range(1));
    data_sel   = 4'($urandom_range(15));
    data_addr  = $urandom & 32'hFFFF_FFFC;
    data_wdata = $urandom;
  endtask

  task automatic model_reset();
    m_owner = 0; m_start = -1; m_end = -1; m_resp = -1; m_ackc = -1;
    m_late = -1; m_free = cyc; m_iack_last = -10; m_dack_last = -10;
    m_streak = 0; m_irdata = 32'h0; m_drdata = 32'h0; m_tmo = 1'b0;
  endtask

  function automatic int pick_lat();
    int r;
    if (lat_mode == 1) return lat_fixed;
    if (lat_mode == 2) return 1000;
    r = int'($urandom_range(99));
    if (r < 80) return int'($urandom_range(5));
    if (r < 90) return TMO - 1;
    return 1000;
  endfunction

  // Decide a grant from this cycle's request levels when the bus is free.
  task automatic model_grant();
    int  lat;
    bit  pick_d;
    if (cyc < m_free) return;
    if (!inst_req && !data_req) return;
    pick_d = data_req && !(inst_req && m_streak == MAXS);
    if (pick_d) begin
      m_streak = inst_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      m_owner = 2; m_addr = data_addr; m_we = data_we; m_sel = data_sel; m_wdata = data_wdata;
    end else begin
      m_streak = 0;
      m_owner = 1; m_addr = inst_addr; m_we = 1'b0; m_sel = 4'hF; m_wdata = 32'h0;
    end
    m_start = cyc + 1;
    lat = pick_lat();
    if (lat >= TMO) begin
      m_end = m_start + TMO - 1; m_tmo = 1'b1; m_ackc = -1; m_rdata = 32'h0;
      m_late = m_end + 1 + ((late_idle != 0) ? 1 : int'($urandom_range(1)));
    end else begin
      m_end = m_start + lat; m_tmo = 1'b0; m_ackc = m_end;
      m_rdata = (rd_fixed_en != 0) ? rd_fixed : $urandom;
    end
    m_resp = m_end + 1;
    m_free = m_resp + 1;
    if (m_owner == 1) m_iack_last = m_resp; else m_dack_last = m_resp;
  endtask

  task automatic drive_bus();
    bit hit;
    hit = (m_owner != 0) && (cyc == m_ackc);
    bus_ack   = hit || (cyc == m_late);
    bus_rdata = hit ? m_rdata : $urandom;
  endtask

  task automatic agents();
    if (inst_req && m_iack_last == cyc - 1) begin
      if (pct(i_renew)) inst_addr = next_iaddr(); else inst_req = 1'b0;
    end else if (!inst_req) begin
      if (cyc > m_iack_last && pct(i_raise)) begin inst_req = 1'b1; inst_addr = next_iaddr(); end
    end else if (pct(i_drop)) begin
      inst_req = 1'b0;
    end
    if (data_req && m_dack_last == cyc - 1) begin
      if (pct(d_renew)) new_dpayload(); else data_req = 1'b0;
    end else if (!data_req) begin
      if (cyc > m_dack_last && pct(d_raise)) begin data_req = 1'b1; new_dpayload(); end
    end else if (pct(d_drop)) begin
      data_req = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit eb, ei, ed;
    eb = (m_owner != 0) && cyc >= m_start && cyc <= m_end;
    ei = (m_owner == 1) && cyc == m_resp;
    ed = (m_owner == 2) && cyc == m_resp;
    if (ei) m_irdata = m_rdata;
    if (ed) m_drdata = m_rdata;
    check_eq("bus_req", bus_req_o, eb);
    if (eb) begin
      check_eq("bus_addr", bus_addr_o, m_addr);
      check_eq("bus_we", bus_we_o, m_we);
      check_eq("bus_sel", bus_sel_o, m_sel);
      if (m_owner == 2) check_eq("bus_wdata", bus_wdata_o, m_wdata);
    end
    check_eq("inst_ack", inst_ack_o, ei);
    check_eq("data_ack", data_ack_o, ed);
    check_eq("err", err_o, (ei || ed) && m_tmo);
    check_eq("inst_rdata", inst_rdata_o, m_irdata);
    check_eq("data_rdata", data_rdata_o, m_drdata);
  endtask

  // One clock cycle: inputs for cycle cyc, then outputs of cycle cyc+1.
  task automatic tick();
    agents();
    model_grant();
    drive_bus();
    #1;
    check_eq("stall", stall_o, (inst_req && !(m_owner == 1 && cyc == m_resp)) ||
                               (data_req && !(m_owner == 2 && cyc == m_resp)));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic knobs_off();
    i_raise = 0; i_renew = 0; i_drop = 0; d_raise = 0; d_renew = 0; d_drop = 0;
    i_seq = 0; late_idle = 0; rd_fixed_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_ack, n_bus, seen, t_i, t_d, r2, a1, n_rise, n_log;
    logic        prev_req;
    logic [6:0]  ack_log;

    rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_we = 1'b0;
    data_sel = 4'h0; data_addr = 32'h0; data_wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    knobs_off(); lat_mode = 0; lat_fixed = 0; rd_fixed = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state
    check_outputs();
    check_eq("rst_addr", bus_addr_o, 32'h0);
    check_eq("rst_sel", bus_sel_o, 4'h0);
    check_eq("rst_we", bus_we_o, 1'b0);
    check_eq("rst_stall", stall_o, 1'b0);
    rst = 1'b0;
    cyc = 0;
    model_reset();

    // fetch only, bus acks two cycles after bus_req_o
    knobs_off(); lat_mode = 1; lat_fixed = 2; rd_fixed_en = 1; rd_fixed = 32'h3c080001;
    inst_req = 1'b1; inst_addr = 32'hbfc00000;
    n_ack = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus_req_o && seen == 0) begin
        seen = 1;
        check_eq("t1_addr", bus_addr_o, 32'hbfc00000);
        check_eq("t1_we", bus_we_o, 1'b0);
        check_eq("t1_sel", bus_sel_o, 4'hF);
      end
      if (inst_ack_o) begin
        n_ack++;
        check_eq("t1_rdata", inst_rdata_o, 32'h3c080001);
      end
    end
    check_eq("t1_seen", seen, 1);
    check_eq("t1_acks", n_ack, 1);
    check_eq("t1_stall", stall_o, 1'b0);

    // collision: data write wins, fetch follows
    knobs_off(); lat_mode = 0;
    inst_req = 1'b1; inst_addr = 32'hbfc00000;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h80000010; data_wdata = 32'hdeadbeef; data_sel = 4'b0011;
    seen = 0; t_i = -1; t_d = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_req_o && seen == 0) begin
        seen = 1;
        check_eq("t2_addr", bus_addr_o, 32'h80000010);
        check_eq("t2_we", bus_we_o, 1'b1);
        check_eq("t2_wdata", bus_wdata_o, 32'hdeadbeef);
        check_eq("t2_sel", bus_sel_o, 4'b0011);
      end
      if (data_ack_o && t_d < 0) t_d = cyc;
      if (inst_ack_o && t_i < 0) t_i = cyc;
    end
    check_eq("t2_order", (t_d >= 0) && (t_i > t_d), 1'b1);

    // back-to-back fetch with the next sequential PC
    knobs_off(); lat_mode = 1; lat_fixed = 0; i_renew = 100; i_seq = 1;
    inst_req = 1'b1; inst_addr = 32'hbfc00000;
    n_ack = 0; n_rise = 0; r2 = -1; a1 = -1; prev_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus_req_o && !prev_req) begin
        n_rise++;
        if (n_rise == 2) begin
          r2 = cyc;
          check_eq("t3_addr2", bus_addr_o, 32'hbfc00004);
          i_renew = 0;
        end
      end
      prev_req = bus_req_o;
      if (inst_ack_o) begin
        n_ack++;
        if (n_ack == 1) a1 = cyc;
      end
    end
    check_eq("t3_gap", r2, a1 + 2);
    check_eq("t3_acks", n_ack, 2);

    // starvation guard with a zero-latency bus
    knobs_off(); lat_mode = 1; lat_fixed = 0;
    d_raise = 100; d_renew = 100; i_raise = 100;
    ack_log = 7'h0; n_log = 0;
    for (int k = 0; k < 60 && n_log < 7; k++) begin
      tick();
      if (data_ack_o) begin ack_log = {ack_log[5:0], 1'b1}; n_log++; end
      if (inst_ack_o) begin ack_log = {ack_log[5:0], 1'b0}; n_log++; end
    end
    check_eq("t4_count", n_log, 7);
    check_eq("t4_order", ack_log, 7'b1111011);
    knobs_off();
    repeat (20) tick();

    // timeout: bus never acks, a late ack lands in IDLE
    knobs_off(); lat_mode = 2; late_idle = 1;
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h80000100; data_wdata = 32'h0;
    n_bus = 0; n_ack = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus_req_o) n_bus++;
      if (data_ack_o) begin
        n_ack++;
        check_eq("t5_err", err_o, 1'b1);
        check_eq("t5_rdata", data_rdata_o, 32'h0);
      end
    end
    check_eq("t5_busreq_cycles", n_bus, TMO);
    check_eq("t5_acks", n_ack, 1);

    // randomized traffic
    knobs_off(); lat_mode = 0;
    i_raise = 30; i_renew = 40; i_drop = 3; d_raise = 35; d_renew = 40; d_drop = 3;
    repeat (3000) tick();
    knobs_off();
    repeat (30) tick();

    // asynchronous reset in the middle of a data transfer
    knobs_off(); lat_mode = 2;
    data_req = 1'b1; data_we = 1'b1; data_sel = 4'hF; data_addr = 32'h80000200; data_wdata = 32'h12345678;
    repeat (3) tick();
    check_eq("t7_busy", bus_req_o, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t7_busreq", bus_req_o, 1'b0);
    check_eq("t7_dack", data_ack_o, 1'b0);
    check_eq("t7_iack", inst_ack_o, 1'b0);
    check_eq("t7_err", err_o, 1'b0);
    data_req = 1'b0; inst_req = 1'b0; bus_ack = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs();
    lat_mode = 1; lat_fixed = 1; rd_fixed_en = 1; rd_fixed = 32'h24020005;
    inst_req = 1'b1; inst_addr = 32'hbfc00000;
    n_ack = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (inst_ack_o) begin
        n_ack++;
        check_eq("t7_rdata", inst_rdata_o, 32'h24020005);
      end
    end
    check_eq("t7_acks", n_ack, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
